nonce_sweeper: RTL and testbench

//  Upstream controller for sha256. Takes a 608-bit header prefix and a nonce range.

---
 rtl/nonce_sweeper.sv | 144 ++++++++++++++
 tb/tb_nonce_sweeper.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_sweeper.sv
// nonce_sweeper: walks a nonce range, launching sha256 on {header, bswap32(nonce)}
// for each nonce and stopping on the first result meeting the leading-zero target.
module nonce_sweeper #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [607:0]     header_in,
  input  logic [31:0]      nonce_start,
  input  logic [31:0]      nonce_end,
  input  logic [8:0]       zbits,
  output logic             sha_start,
  output logic [639:0]     sha_block,
  input  logic [255:0]     sha_hash,
  input  logic             sha_done,
  output logic             busy,
  output logic             found,
  output logic             exhausted,
  output logic [31:0]      found_nonce,
  output logic [255:0]     found_hash,
  output logic [CNT_W-1:0] hashes_tried
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_CHECK  = 2'd3;

  localparam logic [255:0]     ONES    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [607:0]     r_hdr;
  logic [31:0]      r_nonce;
  logic [31:0]      r_end;
  logic [8:0]       r_zbits;
  logic [255:0]     r_hash;
  logic             r_done_d;
  logic             r_found;
  logic             r_exh;
  logic [31:0]      r_fnonce;
  logic [255:0]     r_fhash;
  logic [CNT_W-1:0] r_cnt;

  logic [255:0]     w_rev;
  logic [255:0]     w_mask;
  logic             w_hit;
  logic             w_done_rise;
  logic [31:0]      w_nonce_sw;

  // Byte-reverse the captured hash so the Bitcoin value's MSB is bit 255.
  always_comb begin
    w_rev = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      w_rev[8*i +: 8] = r_hash[255 - 8*i -: 8];
    end
  end

  // Top-zbits mask; zbits==0 yields an empty mask (always a hit), 256 covers all bits.
  assign w_mask      = ~(ONES >> r_zbits);
  assign w_hit       = ((w_rev & w_mask) == '0);
  assign w_done_rise = sha_done & ~r_done_d;
  assign w_nonce_sw  = {r_nonce[7:0], r_nonce[15:8], r_nonce[23:16], r_nonce[31:24]};

  assign sha_start    = (r_state == S_LAUNCH) && !rst && !abort;
  assign sha_block    = {r_hdr, w_nonce_sw};
  assign busy         = (r_state != S_IDLE);
  assign found        = r_found;
  assign exhausted    = r_exh;
  assign found_nonce  = r_fnonce;
  assign found_hash   = r_fhash;
  assign hashes_tried = r_cnt;

  // Sweep state machine; abort overrides everything except reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_hdr    <= '0;
      r_nonce  <= '0;
      r_end    <= '0;
      r_zbits  <= '0;
      r_hash   <= '0;
      r_done_d <= 1'b0;
      r_found  <= 1'b0;
      r_exh    <= 1'b0;
      r_fnonce <= '0;
      r_fhash  <= '0;
      r_cnt    <= '0;
    end else begin
      // Tracked in every state so a done level left over from an aborted run is not an edge.
      r_done_d <= sha_done;
      if (abort) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_hdr   <= header_in;
              r_nonce <= nonce_start;
              r_end   <= nonce_end;
              r_zbits <= zbits;
              r_found <= 1'b0;
              r_exh   <= 1'b0;
              r_cnt   <= '0;
              r_state <= S_LAUNCH;
            end
          end
          S_LAUNCH: begin
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (w_done_rise) begin
              r_hash <= sha_hash;
              if (r_cnt != '1) begin
                r_cnt <= r_cnt + CNT_ONE;
              end
              r_state <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (w_hit) begin
              r_found  <= 1'b1;
              r_fnonce <= r_nonce;
              r_fhash  <= r_hash;
              r_state  <= S_IDLE;
            end else if (r_nonce == r_end) begin
              r_exh   <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_nonce <= r_nonce + 32'd1;
              r_state <= S_LAUNCH;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nonce_sweeper.sv
// Scoreboard bench for nonce_sweeper with a behavioural double-SHA-256 downstream model.
module tb_nonce_sweeper;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [607:0] header_in = '0;
  logic [31:0]  nonce_start = '0;
  logic [31:0]  nonce_end = '0;
  logic [8:0]   zbits = '0;
  logic         sha_start;
  logic [639:0] sha_block;
  logic [255:0] sha_hash = '0;
  logic         sha_done = 1'b0;
  logic         busy;
  logic         found;
  logic         exhausted;
  logic [31:0]  found_nonce;
  logic [255:0] found_hash;
  logic [31:0]  hashes_tried;

  int n_checks = 0;
  int n_err    = 0;

  nonce_sweeper #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .header_in(header_in), .nonce_start(nonce_start), .nonce_end(nonce_end),
    .zbits(zbits), .sha_start(sha_start), .sha_block(sha_block),
    .sha_hash(sha_hash), .sha_done(sha_done), .busy(busy), .found(found),
    .exhausted(exhausted), .found_nonce(found_nonce), .found_hash(found_hash),
    .hashes_tried(hashes_tried)
  );

  always #5 clk = ~clk;

  localparam logic [607:0] GEN_HDR = {32'h01000000, 256'h0,
    256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
    32'h29ab5f49, 32'hffff001d};
  localparam logic [607:0] B1_HDR = {32'h01000000,
    256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000,
    256'h982051fd1e4ba744bbbe680e1fee14677ba1a3c3540bf7b1cdb606e857233e0e,
    32'h61bc6649, 32'hffff001d};
  localparam logic [255:0] GEN_HASH =
    256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;
  localparam logic [255:0] B1_HASH =
    256'h4860eb18bf1b1620e37e9490fc8a427514416fd75159ab86688e9a8300000000;

  // ---------------- SHA-256 reference (downstream model) ----------------
  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [255:0] H_INIT = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                     32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_cmp(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {a + hin[255:224], b + hin[223:192], c + hin[191:160], d + hin[159:128],
            e + hin[127:96],  f + hin[95:64],   g + hin[63:32],   h + hin[31:0]};
  endfunction

  function automatic logic [255:0] sha256d(input logic [639:0] msg);
    logic [255:0] st;
    st = sha_cmp(H_INIT, msg[639:128]);
    st = sha_cmp(st, {msg[127:0], 8'h80, 312'h0, 64'd640});
    return sha_cmp(H_INIT, {st, 8'h80, 184'h0, 64'd256});
  endfunction

  // Downstream model: done stays high after completion and only drops two cycles
  // into the next job; the hash output carries junk until completion.
  localparam int LAT = 6;
  logic [255:0] m_pend = '0;
  int           m_cnt  = 0;
  always @(posedge clk) begin
    if (sha_start) begin
      m_pend   <= sha256d(sha_block);
      sha_hash <= '1;
      m_cnt    <= LAT;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == LAT - 1) sha_done <= 1'b0;
      if (m_cnt == 1) begin
        sha_done <= 1'b1;
        sha_hash <= m_pend;
      end
    end
  end

  // ---------------- Scoreboard ----------------
  typedef struct {
    logic         found;
    logic         exh;
    logic [31:0]  nonce;
    logic [255:0] hash;
    logic [31:0]  tried;
  } res_t;

  res_t         res_q[$];
  logic [639:0] blk_q[$];

  task automatic chk(input string nm, input logic [639:0] act, input logic [639:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic exp_res(input logic f, input logic x, input logic [31:0] n,
                         input logic [255:0] h, input logic [31:0] t);
    res_t r;
    r.found = f; r.exh = x; r.nonce = n; r.hash = h; r.tried = t;
    res_q.push_back(r);
  endtask

  task automatic exp_blk(input logic [607:0] hdr, input logic [31:0] word);
    blk_q.push_back({hdr, word});
  endtask

  // Monitor: compares each launch against the block queue and each busy fall against the result queue.
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    logic [639:0] eb;
    res_t er;
    if (rst) begin
      prev_busy = 1'b0;
    end else begin
      if (sha_start) begin
        if (blk_q.size() == 0) begin
          chk("unexpected_launch", {639'h0, sha_start}, 640'h0);
        end else begin
          eb = blk_q.pop_front();
          chk("blk_nonce", {608'h0, sha_block[31:0]}, {608'h0, eb[31:0]});
          chk("blk_header", {32'h0, sha_block[639:32]}, {32'h0, eb[639:32]});
        end
      end
      if (prev_busy && !busy) begin
        if (res_q.size() == 0) begin
          chk("unexpected_result", {639'h0, prev_busy}, 640'h0);
        end else begin
          er = res_q.pop_front();
          chk("found", {639'h0, found}, {639'h0, er.found});
          chk("exhausted", {639'h0, exhausted}, {639'h0, er.exh});
          chk("hashes_tried", {608'h0, hashes_tried}, {608'h0, er.tried});
          if (er.found) begin
            chk("found_nonce", {608'h0, found_nonce}, {608'h0, er.nonce});
            chk("found_hash", {384'h0, found_hash}, {384'h0, er.hash});
          end
        end
      end
      prev_busy = busy;
    end
  end

  // ---------------- Stimulus ----------------
  task automatic run(input logic [607:0] hdr, input logic [31:0] ns, input logic [31:0] ne,
                     input logic [8:0] z);
    @(posedge clk); #1;
    header_in = hdr; nonce_start = ns; nonce_end = ne; zbits = z; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_results(input string nm);
    int n = 0;
    while ((res_q.size() != 0 || blk_q.size() != 0) && n < 3000) begin
      @(posedge clk); n++;
    end
    if (res_q.size() != 0 || blk_q.size() != 0) begin
      n_checks++; n_err++;
      $display("FAIL %s: timeout with %0d results and %0d blocks pending (required 0)",
               nm, res_q.size(), blk_q.size());
      res_q.delete(); blk_q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_blocks(input string nm);
    int n = 0;
    while (blk_q.size() != 0 && n < 3000) begin
      @(posedge clk); n++;
    end
    if (blk_q.size() != 0) begin
      n_checks++; n_err++;
      $display("FAIL %s: timeout with %0d blocks pending (required 0)", nm, blk_q.size());
      blk_q.delete();
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"}, {639'h0, busy}, 640'h0);
    chk({nm, "_found"}, {639'h0, found}, 640'h0);
    chk({nm, "_exhausted"}, {639'h0, exhausted}, 640'h0);
    chk({nm, "_found_nonce"}, {608'h0, found_nonce}, 640'h0);
    chk({nm, "_found_hash"}, {384'h0, found_hash}, 640'h0);
    chk({nm, "_hashes_tried"}, {608'h0, hashes_tried}, 640'h0);
    chk({nm, "_sha_start"}, {639'h0, sha_start}, 640'h0);
    chk({nm, "_sha_block"}, sha_block, 640'h0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // T1: genesis nonce, 43 zero bits required -> hit
    exp_blk(GEN_HDR, 32'h1DAC2B7C);
    exp_res(1'b1, 1'b0, 32'h7C2BAC1D, GEN_HASH, 32'd1);
    run(GEN_HDR, 32'h7C2BAC1D, 32'h7C2BAC1D, 9'd43);
    wait_results("T1");

    // T2: one bit more than the genesis hash has -> exhausted
    exp_blk(GEN_HDR, 32'h1DAC2B7C);
    exp_res(1'b0, 1'b1, 32'h0, 256'h0, 32'd1);
    run(GEN_HDR, 32'h7C2BAC1D, 32'h7C2BAC1D, 9'd44);
    wait_results("T2");

    // T3: small range around the genesis nonce; a start while busy must be ignored
    exp_blk(GEN_HDR, 32'h1BAC2B7C);
    exp_blk(GEN_HDR, 32'h1CAC2B7C);
    exp_blk(GEN_HDR, 32'h1DAC2B7C);
    exp_res(1'b1, 1'b0, 32'h7C2BAC1D, GEN_HASH, 32'd3);
    run(GEN_HDR, 32'h7C2BAC1B, 32'h7C2BAC1F, 9'd32);
    repeat (3) @(posedge clk);
    run(B1_HDR, 32'h0, 32'h0, 9'd0);
    wait_results("T3");

    // T4: block 1 header at exactly 32 and 33 zero bits
    exp_blk(B1_HDR, 32'h01E36299);
    exp_res(1'b1, 1'b0, 32'h9962E301, B1_HASH, 32'd1);
    run(B1_HDR, 32'h9962E301, 32'h9962E301, 9'd32);
    wait_results("T4a");
    exp_blk(B1_HDR, 32'h01E36299);
    exp_res(1'b0, 1'b1, 32'h0, 256'h0, 32'd1);
    run(B1_HDR, 32'h9962E301, 32'h9962E301, 9'd33);
    wait_results("T4b");

    // T5: range wraps through 0xFFFFFFFF, impossible difficulty
    exp_blk(GEN_HDR, 32'hFEFFFFFF);
    exp_blk(GEN_HDR, 32'hFFFFFFFF);
    exp_blk(GEN_HDR, 32'h00000000);
    exp_blk(GEN_HDR, 32'h01000000);
    exp_res(1'b0, 1'b1, 32'h0, 256'h0, 32'd4);
    run(GEN_HDR, 32'hFFFFFFFE, 32'h00000001, 9'd256);
    wait_results("T5");

    // T6a: abort while waiting on the second hash; counters keep their values
    exp_blk(GEN_HDR, 32'h10000000);
    exp_blk(GEN_HDR, 32'h11000000);
    exp_res(1'b0, 1'b0, 32'h0, 256'h0, 32'd1);
    run(GEN_HDR, 32'h00000010, 32'h00000020, 9'd256);
    wait_blocks("T6a_launch");
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", {639'h0, busy}, 640'h0);
    repeat (20) @(posedge clk);
    wait_results("T6a");

    // start and abort together: abort wins, nothing is cleared or launched
    @(posedge clk); #1;
    header_in = GEN_HDR; nonce_start = 32'h0; nonce_end = 32'h0; zbits = 9'd0;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", {639'h0, busy}, 640'h0);
    chk("start_abort_tried", {608'h0, hashes_tried}, {608'h0, 32'd1});
    repeat (10) @(posedge clk);

    // T6b: reset in the middle of a sweep
    exp_blk(GEN_HDR, 32'h00000000);
    exp_blk(GEN_HDR, 32'h01000000);
    exp_blk(GEN_HDR, 32'h02000000);
    run(GEN_HDR, 32'h00000000, 32'h00000100, 9'd256);
    wait_blocks("T6b_launch");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);

    // T6c: T1 again after the reset
    exp_blk(GEN_HDR, 32'h1DAC2B7C);
    exp_res(1'b1, 1'b0, 32'h7C2BAC1D, GEN_HASH, 32'd1);
    run(GEN_HDR, 32'h7C2BAC1D, 32'h7C2BAC1D, 9'd43);
    wait_results("T6c");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
